// File: rtl/adc_stream_buffer_pkg.sv
// Shared sizing helpers for the ADC stream buffer.
// Latency: n/a (compile-time constants and functions only).
// Backpressure: n/a.
package adc_stream_pkg;

  // Width of the saturating lost-sample counter.
  localparam int DROP_W = 16;

  // Channel tag width; a single channel still needs a 1-bit tag.
  function automatic int ch_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  // Occupancy width; one extra bit so a full FIFO (== depth) is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/adc_stream_buffer_fifo.sv
// Generic single-clock FIFO, first-word-fall-through with registered dout.
// Latency: word pushed at edge n appears on dout after edge n+1 when empty.
// Backpressure: push ignored while full (even with a pop that cycle); pop ignored while empty.
//
// Ports: clk, rst (sync, active-high), flush (sync empty), push/din, pop,
//        dout (head word), empty (no head word), full, usedw (0..DEPTH).
module sync_fifo
  import adc_stream_pkg::*;
#(
  parameter int WIDTH = 18,
  parameter int DEPTH = 512,
  localparam int AW = $clog2(DEPTH),
  localparam int CNT_W = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] usedw
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             out_vld;
  logic             do_push;
  logic             do_pop;
  logic             do_load;
  logic [CNT_W-1:0] ram_cnt;

  assign full    = (usedw == CNT_W'(DEPTH));
  assign empty   = ~out_vld;
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & out_vld;
  // usedw counts the word held in dout too; ram_cnt is what is still queued behind it.
  assign ram_cnt = usedw - CNT_W'(out_vld);
  assign do_load = (~out_vld | do_pop) & (ram_cnt != '0);

  // Storage has no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      usedw   <= '0;
      out_vld <= 1'b0;
      dout    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_load) begin
        dout    <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + AW'(1);
        out_vld <= 1'b1;
      end else if (do_pop) begin
        out_vld <= 1'b0;
      end
      case ({do_push, do_pop})
        2'b10:   usedw <= usedw + CNT_W'(1);
        2'b01:   usedw <= usedw - CNT_W'(1);
        default: usedw <= usedw;
      endcase
    end
  end

endmodule

// File: rtl/adc_stream_buffer.sv
// Multi-channel ADC strobe capture, round-robin merge into one tagged sample stream.
// Latency: drdy_n low sampled at edge k -> o_valid after edge k+5 (FIFO empty, channel granted).
// Backpressure: i_ready stalls the FIFO; when full, samples wait in holding regs and a
//               further strobe on a waiting channel overwrites it (overrun + drop count).
//
// Ports: mclk, i_rest (sync, active-high), i_enable, i_clr (sync flush),
//        i_drdy_n/i_data (per-channel strobe + data), o_valid/i_ready/o_data/o_chan
//        (output stream), o_usedw, o_overrun, o_drop_cnt.
module adc_stream_buffer
  import adc_stream_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CHANNELS = 2,
  parameter int DEPTH = 512,
  localparam int CH_W = ch_w(CHANNELS),
  localparam int CNT_W = cnt_w(DEPTH)
) (
  input  logic                       mclk,
  input  logic                       i_rest,
  input  logic                       i_enable,
  input  logic                       i_clr,
  input  logic [CHANNELS-1:0]        i_drdy_n,
  input  logic [CHANNELS*DATA_W-1:0] i_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [DATA_W-1:0]          o_data,
  output logic [CH_W-1:0]            o_chan,
  output logic [CNT_W-1:0]           o_usedw,
  output logic                       o_overrun,
  output logic [DROP_W-1:0]          o_drop_cnt
);

  logic [CHANNELS-1:0]    drdy_s1;
  logic [CHANNELS-1:0]    drdy_s2;
  logic [CHANNELS-1:0]    drdy_hist;
  logic [CHANNELS-1:0]    fall_q;
  logic [1:0]             warm_cnt;
  logic                   warm_done;
  logic [CHANNELS-1:0]    pending;
  logic [CHANNELS-1:0]    capture;
  logic [CHANNELS-1:0]    granted;
  logic [CHANNELS-1:0]    dropped;
  logic [DATA_W-1:0]      hold [CHANNELS];
  logic [CH_W-1:0]        rr_ptr;
  logic [CH_W-1:0]        rr_next;
  logic [CH_W-1:0]        grant_idx;
  logic [CH_W:0]          idx_sum;
  logic                   grant_vld;
  logic                   push;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CH_W+DATA_W-1:0] fifo_din;
  logic [CH_W+DATA_W-1:0] fifo_dout;
  logic [DROP_W:0]        drop_sum;

  // The chain resets to 1 (line idle), but those are not real line samples. Edge
  // detection stays masked until sync2 and history both hold post-reset samples,
  // so a drdy_n already low when reset releases is not mistaken for a new strobe.
  assign warm_done = (warm_cnt == 2'd3);

  always_ff @(posedge mclk) begin
    if (i_rest) begin
      drdy_s1   <= '1;
      drdy_s2   <= '1;
      drdy_hist <= '1;
      fall_q    <= '0;
      warm_cnt  <= '0;
    end else begin
      drdy_s1   <= i_drdy_n;
      drdy_s2   <= drdy_s1;
      drdy_hist <= drdy_s2;
      fall_q    <= {CHANNELS{warm_done}} & ~drdy_s2 & drdy_hist;
      if (!warm_done) begin
        warm_cnt <= warm_cnt + 2'd1;
      end
    end
  end

  // Round-robin: first pending channel at or after rr_ptr, wrapping at CHANNELS.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    idx_sum   = '0;
    if (!fifo_full) begin
      for (int i = 0; i < CHANNELS; i++) begin
        idx_sum = {1'b0, rr_ptr} + (CH_W+1)'(i);
        if (idx_sum >= (CH_W+1)'(CHANNELS)) begin
          idx_sum = idx_sum - (CH_W+1)'(CHANNELS);
        end
        if (!grant_vld && pending[idx_sum[CH_W-1:0]]) begin
          grant_vld = 1'b1;
          grant_idx = idx_sum[CH_W-1:0];
        end
      end
    end
  end

  assign rr_next  = (grant_idx == CH_W'(CHANNELS - 1)) ? '0 : grant_idx + CH_W'(1);
  assign push     = grant_vld & ~i_clr;
  assign granted  = push ? (CHANNELS'(1) << grant_idx) : '0;
  assign capture  = fall_q & {CHANNELS{i_enable & ~i_clr}};
  // A granted channel hands its old sample to the FIFO this cycle, so a new edge
  // on it just refills the holding register and is not a loss.
  assign dropped  = capture & pending & ~granted;
  assign fifo_din = {grant_idx, hold[grant_idx]};

  always_comb begin
    drop_sum = {1'b0, o_drop_cnt};
    for (int c = 0; c < CHANNELS; c++) begin
      drop_sum = drop_sum + (DROP_W+1)'(dropped[c]);
    end
  end

  always_ff @(posedge mclk) begin
    if (i_rest) begin
      for (int c = 0; c < CHANNELS; c++) begin
        hold[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (capture[c]) begin
          hold[c] <= i_data[c*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (i_rest || i_clr) begin
      pending    <= '0;
      rr_ptr     <= '0;
      o_overrun  <= 1'b0;
      o_drop_cnt <= '0;
    end else begin
      pending <= (pending & ~granted) | capture;
      if (push) begin
        rr_ptr <= rr_next;
      end
      if (|dropped) begin
        o_overrun <= 1'b1;
      end
      o_drop_cnt <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    end
  end

  sync_fifo #(
    .WIDTH (CH_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (mclk),
    .rst   (i_rest),
    .flush (i_clr),
    .push  (push),
    .din   (fifo_din),
    .pop   (i_ready),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .usedw (o_usedw)
  );

  assign o_valid          = ~fifo_empty;
  assign {o_chan, o_data} = fifo_dout;

endmodule
